ej32_br_unit: RTL and testbench
===============================

# ej32_br_unit

Parametrised branching and return-stack unit for the eJ32 Java Forth Machine. It is the successor to the single-width branching unit. It accepts one decoded opcode at a time through a valid/ready handshake and fetches 16-bit branch operands from the byte stream. It resolves conditional, unconditional, call/return and eForth loop ops, and keeps a configurable-depth return stack with overflow, underflow and illegal-op detection. It sits between the decoder/fetch unit and the instruction-pointer mux.

## Interface
- DSZ, 32: data width
- ASZ, 17: instruction address width
- RS_DEPTH, 16: return-stack entries, power of two, at least 2
- REL, 1: 1 means Java-relative signed offsets; 0 means absolute 16-bit targets

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- op_vld  in  1  opcode valid
- op_rdy  out  1  unit idle and able to accept an opcode
- op  in  8  opcode (opcode_t)
- op_pc  in  ASZ  address of the opcode byte
- t  in  DSZ  TOS; sampled at accept
- s  in  DSZ  NOS; sampled at accept
- b_vld  in  1  operand byte valid
- b_rdy  out  1  unit consumes an operand byte this cycle
- b_data  in  8  operand byte
- done  out  1  one-cycle completion pulse
- taken  out  1  when done: branch/jump taken
- tgt  out  ASZ  when done: next instruction address
- t_we  out  1  when done: write t_o to TOS
- t_o  out  DSZ  TOS write data
- r_o  out  DSZ  current top of return stack; 0 when empty
- rp_o  out  $clog2(RS_DEPTH)+1  entry count
- err  out  3  sticky {ill, unf, ovf}
- err_clr  in  1  clears err, synchronous

## Operation
- FSM states: IDLE, OPH, OPL, EXEC.
  - IDLE: op_rdy=1. On op_vld, latch op, op_pc, t and s.
  - After accept, go to OPH if the op takes a 16-bit operand; otherwise go to EXEC.
  - OPH: b_rdy=1. On b_vld, latch the high byte and go to OPL.
  - OPL: same as OPH for the low byte, then go to EXEC.
  - EXEC: done=1, stack update, return to IDLE.
- Operand ops: ifeq..ifle, if_icmpeq..if_icmple, goto, jsr, invokevirtual, donext.
- Target:
  - REL=1: op_pc + sign_extend(off16), modulo 2^ASZ.
  - REL=0: off16 zero-extended or truncated to ASZ.
  - Fall-through: op_pc+3 for operand ops, op_pc+1 otherwise.
  - When taken=0, tgt carries the fall-through address.
- Conditions:
  - if* ops test t: zero, or sign of t.
  - if_icmp* ops compare s (value1) against t (value2) as signed (DSZ+1)-bit values. There is no subtraction-sign shortcut, so no overflow error is possible.
- Ops:
  - goto: taken.
  - jsr: taken; t_we=1, t_o = op_pc+3 zero-extended.
  - invokevirtual: push op_pc+3, taken.
  - jreturn: pop, tgt = r[ASZ-1:0], taken.
  - ret: tgt = r, taken, no pop.
  - donext:
    - r==0: pop, not taken.
    - Otherwise: r ← r−1 in place, taken.
  - pushr: push t.
  - popr: t_o=r, t_we=1, pop.
  - dupr: t_o=r, t_we=1.
- Boundary conditions:
  - Push when full: set ovf; no write; rp unchanged. Any jump still completes.
  - Pop or in-place update when empty: set unf; rp stays 0; r read as 0. donext on empty is not taken.
  - Unsupported opcode: set ill; done with taken=0, tgt=op_pc+1, no side effects.
  - err_clr in the same cycle as a new error: the new error wins.

## Timing
- Reset values: state IDLE, rp_o=0, err=0. done, taken, t_we and b_rdy are 0; tgt=0, t_o=0, r_o=0. Reset mid-operation aborts at once and drops any partial operand.
- Accept happens on the edge where op_vld & op_rdy.
- Latency:
  - No-operand ops: done is asserted 1 cycle after accept.
  - Operand ops: done is asserted 1 cycle after the low byte is consumed, so at least 3 cycles.
- b_vld stalls are unbounded; the FSM holds in OPH or OPL.
- r_o and rp_o update on the EXEC edge and are visible in the cycle after done.
- op_rdy is low from accept through EXEC. Back-to-back ops can be accepted in the cycle after done.

## Structure
- ej32_pkg gains:
  - br_state_e (IDLE/OPH/OPL/EXEC).
  - opcode constants for donext, dupr, popr and pushr.
  - function has_operand(opcode_t).
- Sub-module ej32_rstack: register-array LIFO with parameters DSZ and RS_DEPTH.
  - Inputs: push, pop, upd, wdata.
  - Outputs: top, cnt, full, empty.
  - Registers reset asynchronously.

## Test plan
- REL=1, op_pc=0x100, ifeq, t=0, bytes 0xFF,0xF0 → done at cycle 3, taken=1, tgt=0x0F0. Same with t=5 → taken=0, tgt=0x103.
- if_icmplt with s=0x80000000, t=0x7FFFFFFF → taken=1 (signed compare, no overflow). if_icmpgt with the same operands → taken=0.
- invokevirtual at 0x200, REL=0, bytes 0x12,0x34 → tgt=0x1234, r_o=0x203, rp_o=1. Then jreturn → tgt=0x203, rp_o=0.
- pushr t=2, then donext loop → taken twice (r=1, then r=0), then not taken with a pop, ending at rp_o=0. A further donext → err[1]=1, taken=0.
- RS_DEPTH+1 pushr → rp_o=RS_DEPTH, err[0]=1, top unchanged. Then err_clr → err=0.
- goto with a 5-cycle b_vld gap between bytes, and rst asserted in OPL on a second op → FSM in IDLE, outputs 0, next op runs cleanly.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared types, opcode constants and decode helpers for the eJ32 branch unit.
package ej32_pkg;

   typedef logic [7:0] opcode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPH  = 2'd1,
      OPL  = 2'd2,
      EXEC = 2'd3
   } br_state_e;

   localparam opcode_t OP_IFEQ          = 8'h99;
   localparam opcode_t OP_IFNE          = 8'h9A;
   localparam opcode_t OP_IFLT          = 8'h9B;
   localparam opcode_t OP_IFGE          = 8'h9C;
   localparam opcode_t OP_IFGT          = 8'h9D;
   localparam opcode_t OP_IFLE          = 8'h9E;
   localparam opcode_t OP_IF_ICMPEQ     = 8'h9F;
   localparam opcode_t OP_IF_ICMPNE     = 8'hA0;
   localparam opcode_t OP_IF_ICMPLT     = 8'hA1;
   localparam opcode_t OP_IF_ICMPGE     = 8'hA2;
   localparam opcode_t OP_IF_ICMPGT     = 8'hA3;
   localparam opcode_t OP_IF_ICMPLE     = 8'hA4;
   localparam opcode_t OP_GOTO          = 8'hA7;
   localparam opcode_t OP_JSR           = 8'hA8;
   localparam opcode_t OP_RET           = 8'hA9;
   localparam opcode_t OP_JRETURN       = 8'hB1;
   localparam opcode_t OP_INVOKEVIRTUAL = 8'hB6;
   // eForth extensions live in the unused 0xCA..0xCD slots
   localparam opcode_t OP_DONEXT        = 8'hCA;
   localparam opcode_t OP_DUPR          = 8'hCB;
   localparam opcode_t OP_POPR          = 8'hCC;
   localparam opcode_t OP_PUSHR         = 8'hCD;

   // Ops followed by a 16-bit big-endian operand in the byte stream.
   function automatic logic has_operand(input opcode_t op);
      return ((op >= OP_IFEQ) && (op <= OP_IF_ICMPLE)) || (op == OP_GOTO) ||
             (op == OP_JSR) || (op == OP_INVOKEVIRTUAL) || (op == OP_DONEXT);
   endfunction

   // Everything this unit knows how to resolve; the rest raises ill.
   function automatic logic is_legal(input opcode_t op);
      return has_operand(op) || (op == OP_RET) || (op == OP_JRETURN) ||
             (op == OP_PUSHR) || (op == OP_POPR) || (op == OP_DUPR);
   endfunction

endpackage

// File: rtl/ej32_br_unit_rstack.sv
// Return stack: register-array LIFO. Push beats pop beats in-place update;
// full/empty guard every write so callers only need to flag the error.
module ej32_rstack
   import ej32_pkg::*;
#(
   parameter int DSZ      = 32,
   parameter int RS_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  logic                        upd,
   input  logic [DSZ-1:0]              wdata,
   output logic [DSZ-1:0]              top,
   output logic [$clog2(RS_DEPTH):0]   cnt,
   output logic                        full,
   output logic                        empty
);

   localparam int AW = $clog2(RS_DEPTH);

   logic [DSZ-1:0] mem [RS_DEPTH];
   logic [AW:0]    cnt_q;
   logic [AW-1:0]  top_idx;

   // Low bits wrap to RS_DEPTH-1 when full, which is exactly the top slot.
   assign top_idx = cnt_q[AW-1:0] - AW'(1);
   assign full    = (cnt_q == (AW+1)'(RS_DEPTH));
   assign empty   = (cnt_q == '0);
   assign top     = empty ? '0 : mem[top_idx];
   assign cnt     = cnt_q;

   // Stack pointer and storage update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         for (int i = 0; i < RS_DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         if (!full) begin
            mem[cnt_q[AW-1:0]] <= wdata;
            cnt_q              <= cnt_q + (AW+1)'(1);
         end
      end else if (pop) begin
         if (!empty) cnt_q <= cnt_q - (AW+1)'(1);
      end else if (upd) begin
         if (!empty) mem[top_idx] <= wdata;
      end
   end

endmodule

// File: rtl/ej32_br_unit.sv
// eJ32 branching and return-stack unit: accepts one decoded op, fetches its
// 16-bit operand if any, resolves the next IP and maintains the return stack.
//
//   state | meaning
//   IDLE  | op_rdy high, waiting for an opcode
//   OPH   | waiting for operand high byte
//   OPL   | waiting for operand low byte
//   EXEC  | done pulse, return-stack update, back to IDLE
module ej32_br_unit
   import ej32_pkg::*;
#(
   parameter int DSZ      = 32,
   parameter int ASZ      = 17,
   parameter int RS_DEPTH = 16,
   parameter int REL      = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       op_vld,
   output logic                       op_rdy,
   input  opcode_t                    op,
   input  logic [ASZ-1:0]             op_pc,
   input  logic [DSZ-1:0]             t,
   input  logic [DSZ-1:0]             s,
   input  logic                       b_vld,
   output logic                       b_rdy,
   input  logic [7:0]                 b_data,
   output logic                       done,
   output logic                       taken,
   output logic [ASZ-1:0]             tgt,
   output logic                       t_we,
   output logic [DSZ-1:0]             t_o,
   output logic [DSZ-1:0]             r_o,
   output logic [$clog2(RS_DEPTH):0]  rp_o,
   output logic [2:0]                 err,
   input  logic                       err_clr
);

   localparam bit IS_REL = (REL != 0);

   br_state_e      state;
   opcode_t        op_q;
   logic [ASZ-1:0] pc_q;
   logic [DSZ-1:0] t_q, s_q;
   logic [7:0]     hi_q;

   logic [DSZ-1:0] r_top;
   logic           rs_full, rs_empty;
   logic           rs_push, rs_pop, rs_upd;
   logic [DSZ-1:0] rs_wdata;
   logic [2:0]     err_new;

   // Results are resolved while entering EXEC: from the live inputs when a
   // no-operand op is accepted, from the latched op once the low byte lands.
   opcode_t        src_op;
   logic [ASZ-1:0] src_pc;
   logic [DSZ-1:0] src_t, src_s;
   logic [15:0]    src_off;
   logic signed [15:0]  off_s;
   logic signed [DSZ:0] s_x, t_x;
   logic [ASZ-1:0] ft, jmp_tgt, exec_ret;
   logic           t_zero, t_neg, s_eq, s_lt;
   logic           res_taken, res_twe, load_res;
   logic [ASZ-1:0] res_tgt;
   logic [DSZ-1:0] res_to;

   assign op_rdy   = (state == IDLE);
   assign b_rdy    = (state == OPH) || (state == OPL);
   assign src_op   = op_rdy ? op    : op_q;
   assign src_pc   = op_rdy ? op_pc : pc_q;
   assign src_t    = op_rdy ? t     : t_q;
   assign src_s    = op_rdy ? s     : s_q;
   assign src_off  = {hi_q, b_data};
   assign off_s    = src_off;
   assign ft       = src_pc + (has_operand(src_op) ? ASZ'(3) : ASZ'(1));
   assign jmp_tgt  = IS_REL ? (src_pc + ASZ'(off_s)) : ASZ'(src_off);
   assign exec_ret = pc_q + ASZ'(3);
   assign t_zero   = (src_t == '0);
   assign t_neg    = src_t[DSZ-1];
   // One extra sign bit makes the signed compare exact for all operands.
   assign s_x      = {src_s[DSZ-1], src_s};
   assign t_x      = {src_t[DSZ-1], src_t};
   assign s_eq     = (src_s == src_t);
   assign s_lt     = (s_x < t_x);
   assign load_res = ((state == IDLE) && op_vld && !has_operand(op)) ||
                     ((state == OPL) && b_vld);
   assign r_o      = r_top;

   // Branch resolution: condition, target and TOS write-back.
   always_comb begin
      res_taken = 1'b0;
      res_tgt   = ft;
      res_twe   = 1'b0;
      res_to    = '0;
      case (src_op)
         OP_IFEQ:          res_taken = t_zero;
         OP_IFNE:          res_taken = !t_zero;
         OP_IFLT:          res_taken = t_neg;
         OP_IFGE:          res_taken = !t_neg;
         OP_IFGT:          res_taken = !t_neg && !t_zero;
         OP_IFLE:          res_taken = t_neg || t_zero;
         OP_IF_ICMPEQ:     res_taken = s_eq;
         OP_IF_ICMPNE:     res_taken = !s_eq;
         OP_IF_ICMPLT:     res_taken = s_lt;
         OP_IF_ICMPGE:     res_taken = !s_lt;
         OP_IF_ICMPGT:     res_taken = !s_lt && !s_eq;
         OP_IF_ICMPLE:     res_taken = s_lt || s_eq;
         OP_GOTO,
         OP_INVOKEVIRTUAL: res_taken = 1'b1;
         OP_JSR: begin
            res_taken = 1'b1;
            res_twe   = 1'b1;
            res_to    = DSZ'(ft);
         end
         OP_RET,
         OP_JRETURN: begin
            res_taken = 1'b1;
            res_tgt   = r_top[ASZ-1:0];
         end
         OP_DONEXT:        res_taken = !rs_empty && (r_top != '0);
         OP_POPR,
         OP_DUPR: begin
            res_twe = 1'b1;
            res_to  = r_top;
         end
         default: ;
      endcase
      if (res_taken && has_operand(src_op)) res_tgt = jmp_tgt;
   end

   // Return-stack side effects and error detection for the op in EXEC.
   always_comb begin
      rs_push  = 1'b0;
      rs_pop   = 1'b0;
      rs_upd   = 1'b0;
      rs_wdata = t_q;
      err_new  = 3'b000;
      if (state == EXEC) begin
         case (op_q)
            OP_INVOKEVIRTUAL: begin
               rs_push  = 1'b1;
               rs_wdata = DSZ'(exec_ret);
            end
            OP_PUSHR:         rs_push = 1'b1;
            OP_JRETURN,
            OP_POPR:          rs_pop  = 1'b1;
            OP_DONEXT: begin
               // Empty reads as zero, so it falls into the pop path and flags unf.
               if (r_top == '0) begin
                  rs_pop = 1'b1;
               end else begin
                  rs_upd   = 1'b1;
                  rs_wdata = r_top - DSZ'(1);
               end
            end
            default:          err_new[2] = !is_legal(op_q);
         endcase
         err_new[0] = rs_push && rs_full;
         err_new[1] = (rs_pop || rs_upd) && rs_empty;
      end
   end

   // Control FSM with registered completion outputs and sticky errors.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         op_q  <= '0;
         pc_q  <= '0;
         t_q   <= '0;
         s_q   <= '0;
         hi_q  <= '0;
         done  <= 1'b0;
         taken <= 1'b0;
         tgt   <= '0;
         t_we  <= 1'b0;
         t_o   <= '0;
         err   <= 3'b000;
      end else begin
         // A fresh error beats a simultaneous clear.
         err <= (err_clr ? 3'b000 : err) | err_new;
         if (load_res) begin
            done  <= 1'b1;
            taken <= res_taken;
            tgt   <= res_tgt;
            t_we  <= res_twe;
            t_o   <= res_to;
         end
         case (state)
            IDLE: begin
               if (op_vld) begin
                  op_q  <= op;
                  pc_q  <= op_pc;
                  t_q   <= t;
                  s_q   <= s;
                  state <= has_operand(op) ? OPH : EXEC;
               end
            end
            OPH: begin
               if (b_vld) begin
                  hi_q  <= b_data;
                  state <= OPL;
               end
            end
            OPL: begin
               if (b_vld) state <= EXEC;
            end
            EXEC: begin
               done  <= 1'b0;
               taken <= 1'b0;
               t_we  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   ej32_rstack #(
      .DSZ      (DSZ),
      .RS_DEPTH (RS_DEPTH)
   ) u_rstack (
      .clk   (clk),
      .rst   (rst),
      .push  (rs_push),
      .pop   (rs_pop),
      .upd   (rs_upd),
      .wdata (rs_wdata),
      .top   (r_top),
      .cnt   (rp_o),
      .full  (rs_full),
      .empty (rs_empty)
   );

endmodule

// File: tb/tb_ej32_br_unit.sv
// Bench for ej32_br_unit: a relative-target and an absolute-target instance
// share stimulus; a queue-based model predicts every cycle's outputs.
module tb_ej32_br_unit;
   import ej32_pkg::*;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        op_vld = 1'b0, b_vld = 1'b0, err_clr = 1'b0;
   logic [7:0]  op = '0, b_data = '0;
   logic [16:0] op_pc = '0;
   logic [31:0] t = '0, s = '0;

   logic        op_rdy_r, b_rdy_r, done_r, taken_r, t_we_r;
   logic        op_rdy_a, b_rdy_a, done_a, taken_a, t_we_a;
   logic [16:0] tgt_r, tgt_a;
   logic [31:0] t_o_r, t_o_a, r_o_r, r_o_a;
   logic [3:0]  rp_r, rp_a;
   logic [2:0]  err_r, err_a;

   always #5 clk = ~clk;

   ej32_br_unit #(.DSZ(32), .ASZ(17), .RS_DEPTH(D), .REL(1)) u_rel (
      .clk(clk), .rst(rst), .op_vld(op_vld), .op_rdy(op_rdy_r), .op(op), .op_pc(op_pc),
      .t(t), .s(s), .b_vld(b_vld), .b_rdy(b_rdy_r), .b_data(b_data), .done(done_r),
      .taken(taken_r), .tgt(tgt_r), .t_we(t_we_r), .t_o(t_o_r), .r_o(r_o_r), .rp_o(rp_r),
      .err(err_r), .err_clr(err_clr));

   ej32_br_unit #(.DSZ(32), .ASZ(17), .RS_DEPTH(D), .REL(0)) u_abs (
      .clk(clk), .rst(rst), .op_vld(op_vld), .op_rdy(op_rdy_a), .op(op), .op_pc(op_pc),
      .t(t), .s(s), .b_vld(b_vld), .b_rdy(b_rdy_a), .b_data(b_data), .done(done_a),
      .taken(taken_a), .tgt(tgt_a), .t_we(t_we_a), .t_o(t_o_a), .r_o(r_o_a), .rp_o(rp_a),
      .err(err_a), .err_clr(err_clr));

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   logic [31:0] mstk[$];
   logic [2:0]  merr = 3'b000;
   bit          chk_en = 1'b0;
   bit          e_idle = 1'b1, e_brdy = 1'b0, e_done = 1'b0;
   bit          e_taken = 1'b0, e_twe = 1'b0;
   logic [16:0] e_tgt_r = '0, e_tgt_a = '0;
   logic [31:0] e_to = '0;
   logic        cap_taken;
   logic [16:0] cap_tgt_r, cap_tgt_a;
   logic [31:0] cap_to;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit tb_has_off(input logic [7:0] o);
      case (o)
         OP_IFEQ, OP_IFNE, OP_IFLT, OP_IFGE, OP_IFGT, OP_IFLE,
         OP_IF_ICMPEQ, OP_IF_ICMPNE, OP_IF_ICMPLT, OP_IF_ICMPGE, OP_IF_ICMPGT, OP_IF_ICMPLE,
         OP_GOTO, OP_JSR, OP_INVOKEVIRTUAL, OP_DONEXT: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit tb_legal(input logic [7:0] o);
      return tb_has_off(o) || o == OP_RET || o == OP_JRETURN || o == OP_PUSHR ||
             o == OP_POPR || o == OP_DUPR;
   endfunction

   function automatic logic [31:0] m_top();
      return (mstk.size() > 0) ? mstk[mstk.size()-1] : 32'd0;
   endfunction

   // Expected completion outputs, from the stack as it stands before the op.
   task automatic predict(input logic [7:0] o, input logic [16:0] pc, input logic [31:0] tv,
                          input logic [31:0] sv, input logic [15:0] off);
      int ti, si, so;
      logic [31:0] r;
      logic [16:0] ft;
      bit tk;
      ti = tv; si = sv;
      so = (off >= 16'h8000) ? int'(off) - 65536 : int'(off);
      r  = m_top();
      ft = tb_has_off(o) ? pc + 17'd3 : pc + 17'd1;
      tk = 1'b0; e_twe = 1'b0; e_to = '0; e_tgt_r = ft; e_tgt_a = ft;
      case (o)
         OP_IFEQ: tk = (ti == 0);
         OP_IFNE: tk = (ti != 0);
         OP_IFLT: tk = (ti < 0);
         OP_IFGE: tk = (ti >= 0);
         OP_IFGT: tk = (ti > 0);
         OP_IFLE: tk = (ti <= 0);
         OP_IF_ICMPEQ: tk = (si == ti);
         OP_IF_ICMPNE: tk = (si != ti);
         OP_IF_ICMPLT: tk = (si < ti);
         OP_IF_ICMPGE: tk = (si >= ti);
         OP_IF_ICMPGT: tk = (si > ti);
         OP_IF_ICMPLE: tk = (si <= ti);
         OP_GOTO, OP_INVOKEVIRTUAL: tk = 1'b1;
         OP_JSR: begin tk = 1'b1; e_twe = 1'b1; e_to = 32'(ft); end
         OP_RET, OP_JRETURN: begin tk = 1'b1; e_tgt_r = r[16:0]; e_tgt_a = r[16:0]; end
         OP_DONEXT: tk = (mstk.size() > 0) && (r != 0);
         OP_POPR, OP_DUPR: begin e_twe = 1'b1; e_to = r; end
         default: ;
      endcase
      if (tk && tb_has_off(o)) begin
         e_tgt_r = 17'(int'(pc) + so);
         e_tgt_a = 17'(off);
      end
      e_taken = tk;
   endtask

   // Stack and error effects of a completed op.
   task automatic commit(input logic [7:0] o, input logic [16:0] pc, input logic [31:0] tv,
                         input bit clr);
      logic [2:0] ne;
      int n;
      ne = 3'b000;
      n  = mstk.size();
      case (o)
         OP_PUSHR:         if (n == D) ne[0] = 1'b1; else mstk.push_back(tv);
         OP_INVOKEVIRTUAL: if (n == D) ne[0] = 1'b1; else mstk.push_back(32'(17'(pc + 17'd3)));
         OP_JRETURN, OP_POPR: if (n == 0) ne[1] = 1'b1; else void'(mstk.pop_back());
         OP_DONEXT: begin
            if (n == 0) ne[1] = 1'b1;
            else if (mstk[n-1] == 0) void'(mstk.pop_back());
            else mstk[n-1] = mstk[n-1] - 32'd1;
         end
         default: if (!tb_legal(o)) ne[2] = 1'b1;
      endcase
      merr = (clr ? 3'b000 : merr) | ne;
   endtask

   task automatic cmp_dut(input string tag, input logic ordy, input logic brdy, input logic dn,
                          input logic tk, input logic [16:0] tg, input logic twe,
                          input logic [31:0] to, input logic [31:0] ro, input logic [3:0] rp,
                          input logic [2:0] er, input logic [16:0] etg);
      chk({tag, ".op_rdy"}, 32'(ordy), 32'(e_idle));
      chk({tag, ".b_rdy"},  32'(brdy), 32'(e_brdy));
      chk({tag, ".done"},   32'(dn),   32'(e_done));
      chk({tag, ".r_o"},    ro,        m_top());
      chk({tag, ".rp_o"},   32'(rp),   32'(mstk.size()));
      chk({tag, ".err"},    32'(er),   32'(merr));
      if (e_done) begin
         chk({tag, ".taken"}, 32'(tk),  32'(e_taken));
         chk({tag, ".tgt"},   32'(tg),  32'(etg));
         chk({tag, ".t_we"},  32'(twe), 32'(e_twe));
         if (e_twe) chk({tag, ".t_o"}, to, e_to);
      end
   endtask

   // Every-cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp_dut("rel", op_rdy_r, b_rdy_r, done_r, taken_r, tgt_r, t_we_r, t_o_r, r_o_r, rp_r, err_r, e_tgt_r);
         cmp_dut("abs", op_rdy_a, b_rdy_a, done_a, taken_a, tgt_a, t_we_a, t_o_a, r_o_a, rp_a, err_a, e_tgt_a);
      end
   end

   task automatic feed_byte(input logic [7:0] v, input int gap);
      for (int g = 0; g < gap; g++) begin
         b_vld = 1'b0; b_data = 8'($urandom);
         @(posedge clk); #1;
      end
      b_vld = 1'b1; b_data = v;
      @(posedge clk); #1;
   endtask

   task automatic run_op(input logic [7:0] o, input logic [16:0] pc, input logic [31:0] tv,
                         input logic [31:0] sv, input logic [15:0] off, input int gap,
                         input bit clr);
      @(negedge clk);
      op_vld = 1'b1; op = o; op_pc = pc; t = tv; s = sv;
      predict(o, pc, tv, sv, off);
      @(posedge clk); #1;
      e_idle = 1'b0;
      op_vld = 1'($urandom); op = 8'($urandom); t = $urandom; s = $urandom;
      if (tb_has_off(o)) begin
         e_brdy = 1'b1;
         feed_byte(off[15:8], gap);
         feed_byte(off[7:0], gap);
         b_vld = 1'b0; e_brdy = 1'b0;
      end
      e_done = 1'b1; err_clr = clr;
      cap_taken = taken_r; cap_tgt_r = tgt_r; cap_tgt_a = tgt_a; cap_to = t_o_r;
      @(posedge clk); #1;
      e_done = 1'b0; e_idle = 1'b1; err_clr = 1'b0; op_vld = 1'b0;
      commit(o, pc, tv, clr);
   endtask

   task automatic clr_err();
      @(negedge clk); err_clr = 1'b1;
      @(posedge clk); #1; err_clr = 1'b0; merr = 3'b000;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, ".op_rdy"}, 32'(op_rdy_r), 32'd1);
      chk({tag, ".b_rdy"},  32'(b_rdy_r),  32'd0);
      chk({tag, ".done"},   32'(done_r | done_a), 32'd0);
      chk({tag, ".taken"},  32'(taken_r), 32'd0);
      chk({tag, ".t_we"},   32'(t_we_r),  32'd0);
      chk({tag, ".tgt"},    32'(tgt_r | tgt_a), 32'd0);
      chk({tag, ".t_o"},    t_o_r, 32'd0);
      chk({tag, ".r_o"},    r_o_r | r_o_a, 32'd0);
      chk({tag, ".rp_o"},   32'(rp_r | rp_a), 32'd0);
      chk({tag, ".err"},    32'(err_r | err_a), 32'd0);
   endtask

   logic [7:0] op_tab[$] = '{OP_IFEQ, OP_IFNE, OP_IFLT, OP_IFGE, OP_IFGT, OP_IFLE,
      OP_IF_ICMPEQ, OP_IF_ICMPNE, OP_IF_ICMPLT, OP_IF_ICMPGE, OP_IF_ICMPGT, OP_IF_ICMPLE,
      OP_GOTO, OP_JSR, OP_RET, OP_JRETURN, OP_INVOKEVIRTUAL, OP_DONEXT, OP_DONEXT,
      OP_DUPR, OP_POPR, OP_PUSHR, OP_PUSHR, OP_PUSHR};

   initial begin
      logic [7:0]  ro;
      logic [31:0] rt, rs;
      repeat (3) @(negedge clk);
      reset_checks("reset");
      rst = 1'b1; chk_en = 1'b1;

      // conditional branches, relative target
      run_op(OP_IFEQ, 17'h100, 32'd0, 32'd0, 16'hFFF0, 0, 1'b0);
      chk("ifeq0.taken", 32'(cap_taken), 32'd1);
      chk("ifeq0.tgt", 32'(cap_tgt_r), 32'h0F0);
      run_op(OP_IFEQ, 17'h100, 32'd5, 32'd0, 16'hFFF0, 0, 1'b0);
      chk("ifeq5.taken", 32'(cap_taken), 32'd0);
      chk("ifeq5.tgt", 32'(cap_tgt_r), 32'h103);
      run_op(OP_IF_ICMPLT, 17'h40, 32'h7FFFFFFF, 32'h80000000, 16'h0010, 0, 1'b0);
      chk("icmplt.taken", 32'(cap_taken), 32'd1);
      run_op(OP_IF_ICMPGT, 17'h40, 32'h7FFFFFFF, 32'h80000000, 16'h0010, 0, 1'b0);
      chk("icmpgt.taken", 32'(cap_taken), 32'd0);

      // call / return
      run_op(OP_INVOKEVIRTUAL, 17'h200, 32'd0, 32'd0, 16'h1234, 0, 1'b0);
      chk("invoke.tgt_abs", 32'(cap_tgt_a), 32'h1234);
      chk("invoke.tgt_rel", 32'(cap_tgt_r), 32'h1434);
      chk("invoke.r_o", r_o_r, 32'h203);
      chk("invoke.rp_o", 32'(rp_r), 32'd1);
      run_op(OP_JRETURN, 17'h1500, 32'd0, 32'd0, 16'h0, 0, 1'b0);
      chk("jreturn.tgt", 32'(cap_tgt_a), 32'h203);
      chk("jreturn.rp_o", 32'(rp_a), 32'd0);

      // donext loop
      run_op(OP_PUSHR, 17'h10, 32'd2, 32'd0, 16'h0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         run_op(OP_DONEXT, 17'h20, 32'd0, 32'd0, 16'hFFF0, 1, 1'b0);
         chk("donext.taken", 32'(cap_taken), (i < 2) ? 32'd1 : 32'd0);
      end
      chk("donext.rp_o", 32'(rp_r), 32'd0);
      run_op(OP_DONEXT, 17'h20, 32'd0, 32'd0, 16'hFFF0, 0, 1'b0);
      chk("donext_empty.taken", 32'(cap_taken), 32'd0);
      chk("donext_empty.tgt", 32'(cap_tgt_r), 32'h23);
      chk("donext_empty.err", 32'(err_r), 32'b010);
      clr_err();

      // overflow, clear, and error-beats-clear
      for (int i = 0; i <= D; i++) run_op(OP_PUSHR, 17'h30, 32'h10 + 32'(i), 32'd0, 16'h0, 0, 1'b0);
      chk("ovf.rp_o", 32'(rp_r), 32'(D));
      chk("ovf.err", 32'(err_r), 32'b001);
      chk("ovf.r_o", r_o_r, 32'h10 + 32'(D - 1));
      clr_err();
      chk("clr.err", 32'(err_a), 32'd0);
      run_op(OP_INVOKEVIRTUAL, 17'h1FFFE, 32'd0, 32'd0, 16'h0100, 0, 1'b1);
      chk("ovf_vs_clr.err", 32'(err_r), 32'b001);
      chk("ovf_call.taken", 32'(cap_taken), 32'd1);
      run_op(OP_POPR, 17'h50, 32'd0, 32'd0, 16'h0, 0, 1'b0);
      chk("popr.t_o", cap_to, 32'h10 + 32'(D - 1));
      clr_err();

      // operand stall, then reset while in OPL
      run_op(OP_GOTO, 17'h400, 32'd0, 32'd0, 16'h0008, 5, 1'b0);
      chk("goto_gap.tgt", 32'(cap_tgt_r), 32'h408);
      @(negedge clk);
      op_vld = 1'b1; op = OP_GOTO; op_pc = 17'h300;
      @(posedge clk); #1;
      op_vld = 1'b0; e_idle = 1'b0; e_brdy = 1'b1; b_vld = 1'b1; b_data = 8'h55;
      @(posedge clk); #1;
      b_vld = 1'b0;
      @(negedge clk); chk_en = 1'b0;
      #2 rst = 1'b0;
      #1 reset_checks("abort");
      mstk.delete(); merr = 3'b000; e_brdy = 1'b0; e_idle = 1'b1;
      @(negedge clk); rst = 1'b1; chk_en = 1'b1;
      run_op(OP_GOTO, 17'h300, 32'd0, 32'd0, 16'h0020, 0, 1'b0);
      chk("after_abort.tgt", 32'(cap_tgt_r), 32'h320);

      // unsupported opcode with wrapping fall-through
      run_op(8'hFF, 17'h1FFFF, 32'd7, 32'd0, 16'h0, 0, 1'b0);
      chk("ill.taken", 32'(cap_taken), 32'd0);
      chk("ill.tgt", 32'(cap_tgt_r), 32'h0);
      chk("ill.err", 32'(err_r), 32'b100);
      clr_err();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            ro = 8'($urandom);
            if (tb_legal(ro)) ro = 8'h00;
         end else begin
            ro = op_tab[$urandom_range(0, op_tab.size() - 1)];
         end
         case ($urandom_range(0, 3))
            0: rt = 32'd0;
            1: rt = 32'($urandom_range(0, 3));
            2: rt = 32'h80000000 ^ 32'($urandom_range(0, 1));
            default: rt = $urandom;
         endcase
         rs = ($urandom_range(0, 3) == 0) ? rt : $urandom;
         run_op(ro, 17'($urandom), rt, rs, 16'($urandom), $urandom_range(0, 2),
                ($urandom_range(0, 9) == 0));
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
